// File: rtl/swbox_cfg_loader_if.sv
// Byte-stream link carrying configuration bytes from the host into the loader.
// Latency: none, this is wiring only.
// Backpressure: byte_ready from the loader qualifies each byte_valid beat.
//
// Signals:
//   byte_in    : config byte; byte_in[j] lands in SRAM[8k+j] for the k-th byte
//   byte_valid : host has a byte on byte_in
//   byte_ready : loader accepts a byte this cycle
interface swbox_cfg_loader_if;
  logic [0:7] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );
endinterface

// File: rtl/swbox_cfg_loader.sv
// SwitchBox config loader: assembles an 8-byte frame, rejects tri-state contention, commits atomically.
// Latency: done and the new SRAM appear 9 edges after the edge that accepts the last byte.
// Backpressure: byte_ready is high only while loading; bytes offered outside LOAD are not consumed.
//
// Ports:
//   clk, rst_n  : rising-edge clock, asynchronous active-low reset
//   start       : begin a new frame (only honoured while idle)
//   bus         : byte stream slave (byte_in / byte_valid / byte_ready)
//   SRAM        : committed 64-bit configuration driving the SwitchBox
//   busy        : a frame is in progress
//   done        : one-cycle pulse when a new SRAM is committed
//   err         : last frame rejected or aborted (sticky until next accepted start)
//   err_mask    : bit k set when group k (SRAM[8k:8k+7]) had more than one enable set
//   timeout     : last frame aborted by the inter-byte idle limit (sticky like err)
module swbox_cfg_loader #(
  parameter bit          CHECK_EN = 1'b1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  swbox_cfg_loader_if.slave     bus,
  output logic [0:63]           SRAM,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [0:7]            err_mask,
  output logic                  timeout
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  // Idle limit truncated to the counter width; zero disables the limit.
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT);

  logic [2:0]  state_q,    state_d;
  logic [0:63] shadow_q,   shadow_d;
  logic [0:63] sram_q,     sram_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [2:0]  grp_cnt_q,  grp_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [0:7]  mask_q,     mask_d;
  logic        tflag_q,    tflag_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;
  logic [0:7]  err_mask_q, err_mask_d;
  logic        timeout_q,  timeout_d;

  logic        handshake;
  logic [0:7]  grp_bits;
  logic        grp_bad;

  // True when more than one enable in the group is set (clearing the lowest
  // set bit leaves something behind).
  function automatic logic multi_hot(input logic [0:7] g);
    logic [7:0] v;
    v = g;
    return (v & (v - 8'd1)) != 8'd0;
  endfunction

  // byte_ready depends on state only, so the host never sees a combinational
  // path from byte_valid back to byte_ready.
  assign bus.byte_ready = (state_q == S_LOAD);
  assign handshake      = bus.byte_valid & bus.byte_ready;

  assign grp_bits = shadow_q[{grp_cnt_q, 3'b000} +: 8];
  assign grp_bad  = CHECK_EN & multi_hot(grp_bits);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    sram_d     = sram_q;
    byte_cnt_d = byte_cnt_q;
    grp_cnt_d  = grp_cnt_q;
    idle_cnt_d = idle_cnt_q;
    mask_d     = mask_q;
    tflag_d    = tflag_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_mask_d = err_mask_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          err_d      = 1'b0;
          timeout_d  = 1'b0;
          err_mask_d = '0;
          byte_cnt_d = '0;
          grp_cnt_d  = '0;
          idle_cnt_d = '0;
          mask_d     = '0;
          tflag_d    = 1'b0;
        end
      end

      S_LOAD: begin
        if (handshake) begin
          shadow_d[{byte_cnt_q, 3'b000} +: 8] = bus.byte_in;
          byte_cnt_d = byte_cnt_q + 3'd1;
          idle_cnt_d = '0;
          if (byte_cnt_q == 3'd7) begin
            state_d   = S_CHECK;
            grp_cnt_d = '0;
          end
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
          // Abort on the edge where the idle count would reach the limit.
          if ((TO_LIMIT != 16'd0) && ((idle_cnt_q + 16'd1) == TO_LIMIT)) begin
            state_d = S_FAIL;
            tflag_d = 1'b1;
          end
        end
      end

      S_CHECK: begin
        mask_d[grp_cnt_q] = grp_bad;
        grp_cnt_d         = grp_cnt_q + 3'd1;
        // The last group's result is folded in before the verdict so the
        // decision does not cost an extra cycle.
        if (grp_cnt_q == 3'd7) begin
          state_d = (mask_d == 8'd0) ? S_COMMIT : S_FAIL;
        end
      end

      S_COMMIT: begin
        sram_d  = shadow_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_FAIL: begin
        err_d      = 1'b1;
        err_mask_d = tflag_q ? 8'd0 : mask_q;
        timeout_d  = tflag_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shadow_q   <= '0;
      sram_q     <= '0;
      byte_cnt_q <= '0;
      grp_cnt_q  <= '0;
      idle_cnt_q <= '0;
      mask_q     <= '0;
      tflag_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      sram_q     <= sram_d;
      byte_cnt_q <= byte_cnt_d;
      grp_cnt_q  <= grp_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      mask_q     <= mask_d;
      tflag_q    <= tflag_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
      timeout_q  <= timeout_d;
    end
  end

  assign SRAM     = sram_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign err_mask = err_mask_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_swbox_cfg_loader.sv
// Bench for swbox_cfg_loader: table of frames plus hand-written timeout and async-reset sequences.
// Two instances share stimulus: A checks contention, B has the check disabled.
module tb_swbox_cfg_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [0:7]  byte_in;
  logic        byte_valid;

  logic [0:63] sram_a, sram_b;
  logic        busy_a, busy_b, done_a, done_b, err_a, err_b, to_a, to_b;
  logic [0:7]  emask_a, emask_b;

  swbox_cfg_loader_if bus_a ();
  swbox_cfg_loader_if bus_b ();

  assign bus_a.byte_in    = byte_in;
  assign bus_a.byte_valid = byte_valid;
  assign bus_b.byte_in    = byte_in;
  assign bus_b.byte_valid = byte_valid;

  swbox_cfg_loader #(.CHECK_EN(1'b1), .TIMEOUT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a.slave),
    .SRAM(sram_a), .busy(busy_a), .done(done_a), .err(err_a),
    .err_mask(emask_a), .timeout(to_a)
  );

  swbox_cfg_loader #(.CHECK_EN(1'b0), .TIMEOUT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_b.slave),
    .SRAM(sram_b), .busy(busy_b), .done(done_b), .err(err_b),
    .err_mask(emask_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] frame;      // byte k = frame[63-8k -: 8]
    int          gap [8];    // idle cycles before byte k
    int          mid_start;  // byte index whose gap carries a stray start pulse, -1 = none
    logic [7:0]  mask_a;     // expected err_mask with the check enabled
  } vec_t;

  vec_t        vecs [7];
  int          n_chk;
  int          n_fail;
  logic [63:0] exp_a;
  logic [63:0] exp_b;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    for (int g = 0; g < gap; g++) begin
      if (pulse_start && g == 0) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    byte_valid = 1'b1;
    byte_in    = b;
    chk("byte_ready_in_load", bus_a.byte_ready, 1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic run_frame(input int i);
    int       da;
    int       db;
    int       done_cyc;
    bit       commit_a;
    commit_a = (vecs[i].mask_a == 8'h00);
    do_start();
    chk("start_clears_err", err_a, 0);
    chk("start_clears_mask", emask_a, 0);
    chk("busy_after_start", busy_a, 1);
    for (int k = 0; k < 8; k++) begin
      send_byte(vecs[i].frame[63 - 8*k -: 8], vecs[i].gap[k], vecs[i].mid_start == k);
    end
    da = 0;
    db = 0;
    done_cyc = -1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("ready_drops_after_last", bus_a.byte_ready, 0);
      if (c == 8) chk("busy_before_verdict", busy_a, 1);
      if (c == 9) chk("busy_after_verdict", busy_a, 0);
      if (done_a) begin
        da++;
        done_cyc = c;
      end
      if (done_b) db++;
    end
    if (commit_a) exp_a = vecs[i].frame;
    exp_b = vecs[i].frame;
    chk("done_count_a", 64'(da), commit_a ? 64'd1 : 64'd0);
    if (commit_a) chk("done_latency_a", 64'(done_cyc), 64'd9);
    chk("err_a", err_a, commit_a ? 64'd0 : 64'd1);
    chk("err_mask_a", emask_a, vecs[i].mask_a);
    chk("timeout_a", to_a, 0);
    chk("sram_a", sram_a, exp_a);
    chk("done_count_b", 64'(db), 1);
    chk("err_b", err_b, 0);
    chk("sram_b", sram_b, exp_b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    exp_a  = '0;
    exp_b  = '0;

    vecs[0] = '{frame: 64'h0102040810204080, gap: '{0,0,0,0,0,0,0,0}, mid_start: -1, mask_a: 8'h00};
    vecs[1] = '{frame: 64'h00108003_0100FF40, gap: '{0,0,0,0,0,0,0,0}, mid_start: -1, mask_a: 8'h12};
    vecs[2] = '{frame: 64'h0000000000000000, gap: '{0,0,0,0,0,0,0,0}, mid_start: -1, mask_a: 8'h00};
    vecs[3] = '{frame: 64'h01800000_000000C0, gap: '{0,0,0,0,0,0,0,0}, mid_start: -1, mask_a: 8'h01};
    vecs[4] = '{frame: 64'h11000000_00000000, gap: '{0,0,0,0,0,0,0,0}, mid_start: -1, mask_a: 8'h80};
    vecs[5] = '{frame: 64'h20400108_00108004, gap: '{0,1,3,2,1,3,1,2}, mid_start: 4,  mask_a: 8'h00};
    vecs[6] = '{frame: 64'hFFFFFFFF_FFFFFFFF, gap: '{0,0,0,0,0,0,0,0}, mid_start: -1, mask_a: 8'hFF};

    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = '0;
    #12 rst_n  = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_sram", sram_a, 0);
    chk("reset_busy", busy_a, 0);
    chk("reset_err", err_a, 0);
    chk("reset_err_mask", emask_a, 0);
    chk("reset_byte_ready", bus_a.byte_ready, 0);
    chk("reset_done", done_a, 0);
    chk("reset_timeout", to_a, 0);

    for (int i = 0; i < 7; i++) begin
      run_frame(i);
    end

    // Inter-byte timeout: three bytes, then silence.
    do_start();
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h04, 0, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin
        chk("timeout_not_yet_err", err_a, 0);
        chk("timeout_not_yet_busy", busy_a, 1);
      end
    end
    chk("timeout_err_a", err_a, 1);
    chk("timeout_flag_a", to_a, 1);
    chk("timeout_mask_a", emask_a, 0);
    chk("timeout_busy_a", busy_a, 0);
    chk("timeout_sram_a", sram_a, exp_a);
    chk("timeout_flag_b", to_b, 1);
    chk("timeout_sram_b", sram_b, exp_b);

    // Next start clears the sticky flags; then reset lands mid-frame.
    do_start();
    chk("restart_clears_err", err_a, 0);
    chk("restart_clears_timeout", to_a, 0);
    for (int k = 0; k < 5; k++) begin
      send_byte(8'h01, 0, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_sram_a", sram_a, 0);
    chk("async_reset_busy_a", busy_a, 0);
    chk("async_reset_ready_a", bus_a.byte_ready, 0);
    chk("async_reset_sram_b", sram_b, 0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_a = '0;
    exp_b = '0;
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
